// File: rtl/uart_word_rx.sv
// uart_word_rx: UART 8N1 receiver that packs BYTES_PER_WORD bytes (LSB byte
// first) into one word and strobes o_valid for a single cycle per word.
// Optional feature macro: UART_RX_TIMEOUT_EN drops a partial word after
// TIMEOUT_BITS idle bit-periods.
module uart_word_rx #(
  parameter int CLKS_PER_BIT   = 104,
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic                          Clk,
  input  logic                          rst,
  input  logic                          i_uart_rx,
  output logic [8*BYTES_PER_WORD-1:0]   o_data,
  output logic                          o_valid,
  output logic                          o_frame_err,
  output logic                          o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_reg, state_next;

  logic                        sync1_reg, sync2_reg, prev_reg;
  logic [1:0]                  fill_reg;
  logic                        armed_reg;
  logic [CNT_W-1:0]            clk_cnt_reg;
  logic [2:0]                  bit_cnt_reg;
  logic [7:0]                  shift_reg;
  logic [IDX_W-1:0]            byte_idx_reg;
  logic [7:0]                  bytes_reg [BYTES_PER_WORD];
  logic [8*BYTES_PER_WORD-1:0] word_next;
  logic                        start_edge, half_tick, bit_tick;
  logic                        stop_sample, stop_good, stop_bad, drop_partial;

  // Synchronizer plus edge history. The sync flops come out of reset at 1, so
  // the line only counts as genuinely idle-high once real samples have filled
  // the pipeline and shown a 1; a line held low through reset is not a start.
  always_ff @(posedge Clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
      fill_reg  <= 2'b00;
      armed_reg <= 1'b0;
    end else begin
      sync1_reg <= i_uart_rx;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      fill_reg  <= {fill_reg[0], 1'b1};
      if (fill_reg[1] && sync2_reg) armed_reg <= 1'b1;
    end
  end

  assign start_edge  = armed_reg & prev_reg & ~sync2_reg;
  assign half_tick   = (state_reg == START) && (clk_cnt_reg == HALF_LAST);
  assign bit_tick    = (clk_cnt_reg == BIT_LAST);
  assign stop_sample = (state_reg == STOP) && bit_tick;
  assign stop_good   = stop_sample & sync2_reg;
  assign stop_bad    = stop_sample & ~sync2_reg;
  assign o_busy      = (state_reg != IDLE);

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: half-bit start check, eight data bits, one stop bit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (start_edge) state_next = START;
      START: if (half_tick) state_next = sync2_reg ? IDLE : DATA;
      DATA:  if (bit_tick && bit_cnt_reg == 3'd7) state_next = STOP;
      STOP:  if (bit_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit timing and data shifting; the clock counter wraps at each bit centre.
  always_ff @(posedge Clk) begin
    if (rst) begin
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else begin
      if (state_reg == IDLE || half_tick || bit_tick) clk_cnt_reg <= '0;
      else                                            clk_cnt_reg <= clk_cnt_reg + 1'b1;
      if (half_tick) bit_cnt_reg <= '0;
      if (state_reg == DATA && bit_tick) begin
        shift_reg   <= {sync2_reg, shift_reg[7:1]};
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

  // Partial-word byte store; stale contents are harmless because the index
  // decides which entries are live.
  always_ff @(posedge Clk) begin
    if (stop_good && byte_idx_reg != IDX_LAST) bytes_reg[byte_idx_reg] <= shift_reg;
  end

  // Final byte comes straight from the shifter, earlier bytes from the store.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_word
    if (gi == BYTES_PER_WORD - 1) begin : g_last
      assign word_next[8*gi +: 8] = shift_reg;
    end else begin : g_stored
      assign word_next[8*gi +: 8] = bytes_reg[gi];
    end
  end

  // Word assembly, strobes and byte index bookkeeping.
  always_ff @(posedge Clk) begin
    if (rst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      byte_idx_reg <= '0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      if (stop_good) begin
        if (byte_idx_reg == IDX_LAST) begin
          o_data       <= word_next;
          o_valid      <= 1'b1;
          byte_idx_reg <= '0;
        end else begin
          byte_idx_reg <= byte_idx_reg + 1'b1;
        end
      end else if (stop_bad) begin
        o_frame_err  <= 1'b1;
        byte_idx_reg <= '0;
      end else if (drop_partial) begin
        byte_idx_reg <= '0;
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
  logic [TO_W-1:0] idle_cnt_reg;

  assign drop_partial = (state_reg == IDLE) && (byte_idx_reg != '0) &&
                        !start_edge && (idle_cnt_reg == TO_LAST);

  // Idle-time counter; only runs while a partial word is waiting in IDLE.
  always_ff @(posedge Clk) begin
    if (rst || start_edge || state_reg != IDLE || byte_idx_reg == '0 || drop_partial)
      idle_cnt_reg <= '0;
    else
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
  end
`else
  assign drop_partial = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: randomized and directed stimulus for uart_word_rx, checked
// against a byte-queue reference model (UART_RX_TIMEOUT_EN aware).
module tb_uart_word_rx;
  localparam int CPB = 4;
  localparam int BPW = 4;
  localparam int TOB = 20;

  logic        Clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b0;
  logic [31:0] o_data;
  logic        o_valid, o_frame_err, o_busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  model_bytes[$];
  int          fe_cnt = 0, exp_fe = 0, both_cnt = 0;
  logic        busy_seen = 1'b0;

  uart_word_rx #(.CLKS_PER_BIT(CPB), .BYTES_PER_WORD(BPW), .TIMEOUT_BITS(TOB)) dut (
    .Clk(Clk), .rst(rst), .i_uart_rx(rx), .o_data(o_data),
    .o_valid(o_valid), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 Clk = ~Clk;

  // Output monitor, sampled away from the active edge.
  always @(negedge Clk) begin
    if (o_valid) got_q.push_back(o_data);
    if (o_frame_err) fe_cnt++;
    if (o_valid && o_frame_err) both_cnt++;
    if (o_busy) busy_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Reference model: good bytes accumulate, a full set becomes a word,
  // a bad stop bit discards everything collected so far.
  task automatic model_byte(input logic [7:0] b, input logic stop_ok);
    logic [31:0] w;
    if (!stop_ok) begin
      exp_fe++;
      model_bytes.delete();
    end else begin
      model_bytes.push_back(b);
      if (model_bytes.size() == BPW) begin
        w = 32'h0;
        for (int i = 0; i < BPW; i++) w = w | (32'(model_bytes[i]) << (8 * i));
        exp_q.push_back(w);
        model_bytes.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    logic [9:0] frame;
    frame = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      rx = frame[i];
      repeat (CPB - 1) @(negedge Clk);
    end
    if (!stop_ok) begin
      @(negedge Clk);
      rx = 1'b1;
    end
    model_byte(b, stop_ok);
  endtask

  task automatic idle_gap(input int n);
    @(negedge Clk);
    rx = 1'b1;
    repeat (n) @(negedge Clk);
`ifdef UART_RX_TIMEOUT_EN
    if (n > TOB * CPB + 4) model_bytes.delete();
`endif
  endtask

  task automatic check_words(input string tag);
    int n;
    idle_gap(3 * CPB + 6);
    check_eq({tag, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    check_eq({tag, "_frame_err"}, 32'(fe_cnt), 32'(exp_fe));
    check_eq({tag, "_overlap"}, 32'(both_cnt), 32'd0);
    got_q.delete();
    exp_q.delete();
    fe_cnt = 0;
    exp_fe = 0;
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;
    // Reset with the line held low; releasing reset into a low line is not a start.
    repeat (3) @(negedge Clk);
    check_eq("rst_data",  o_data, 32'h0);
    check_eq("rst_valid", 32'(o_valid), 32'h0);
    check_eq("rst_ferr",  32'(o_frame_err), 32'h0);
    check_eq("rst_busy",  32'(o_busy), 32'h0);
    rst = 1'b0;
    busy_seen = 1'b0;
    repeat (20) @(negedge Clk);
    check_eq("low_at_reset_busy", 32'(busy_seen), 32'h0);
    rx = 1'b1;
    repeat (10) @(negedge Clk);

    // 1: single word
    send_byte(8'h3F, 1'b1); send_byte(8'hE2, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    check_eq("t1_expected_const", exp_q[0], 32'h0001E23F);
    check_words("t1");

    // 2: two words back to back
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
    check_words("t2");

    // 3: framing error on the second byte, then a clean word
    send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b0); idle_gap(CPB);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    check_words("t3");
    check_eq("t3_data", o_data, 32'h04030201);

    // 4: one-cycle glitch is rejected at the half-bit check
    busy_seen = 1'b0;
    @(negedge Clk); rx = 1'b0;
    @(negedge Clk); rx = 1'b1;
    repeat (CPB + 6) @(negedge Clk);
    check_eq("t4_busy_seen", 32'(busy_seen), 32'h1);
    check_eq("t4_busy_low",  32'(o_busy), 32'h0);
    check_words("t4");

    // 5: reset mid-word
    send_byte(8'hA5, 1'b1); send_byte(8'h5A, 1'b1);
    @(negedge Clk); rst = 1'b1; rx = 1'b1;
    @(negedge Clk); rst = 1'b0;
    model_bytes.delete();
    check_eq("t5_rst_data", o_data, 32'h0);
    repeat (6) @(negedge Clk);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    check_words("t5");

    // Randomized bytes, gaps and occasional framing errors
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send_byte(b, ok);
      if (!ok)                         idle_gap($urandom_range(CPB, 2 * CPB));
      else if ($urandom_range(0, 1))   idle_gap($urandom_range(0, 6));
    end
    send_byte(8'h00, 1'b0); idle_gap(CPB);
    for (int i = 0; i < BPW; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    check_words("rand");

    // 6: long idle after three bytes, then a full word
    send_byte(8'h9A, 1'b1); send_byte(8'hBC, 1'b1); send_byte(8'hDE, 1'b1);
    idle_gap(100);
    send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
    check_words("t6");
    check_eq("t6_top_byte", 32'(o_data[31:24]), 32'(8'hDE ^
`ifdef UART_RX_TIMEOUT_EN
      8'h00
`else
      8'h31
`endif
      ));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
